// File: rtl/lm32_dtlb_nway.sv
// N-way set-associative data TLB for the LM32 load/store path: registered X-stage read, M-stage compare.
// Optional write-protect bit per entry and sticky fault when CFG_DTLB_WRITE_PROTECT_EN is defined.
module lm32_dtlb_nway #(
  parameter int ways      = 2,
  parameter int sets      = 256,
  parameter int page_size = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable,
  input  logic        stall_x,
  input  logic        stall_m,
  input  logic [31:0] address_x,
  input  logic [31:0] address_m,
  input  logic        load_q_m,
  input  logic        store_q_m,
  input  logic [4:0]  csr,
  input  logic [31:0] csr_write_data,
  input  logic        csr_write_enable,
  input  logic        exception_m,
  output logic [31:0] physical_load_store_address_m,
  output logic        stall_request,
  output logic        miss_int,
  output logic        fault_int,
  output logic [31:0] csr_read_data
);
  localparam int offset_w = $clog2(page_size);
  localparam int index_w  = $clog2(sets);
  localparam int tag_w    = 32 - offset_w - index_w;
  localparam int pfn_w    = 32 - offset_w;
  localparam int way_w    = (ways > 1) ? $clog2(ways) : 1;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
  localparam int data_w   = pfn_w + 1;
`else
  localparam int data_w   = pfn_w;
`endif
  localparam logic [4:0] csr_tlb_paddress = 5'h11;
  localparam logic [4:0] csr_tlb_vaddress = 5'h12;

  typedef enum logic [0:0] {st_check, st_flush} state_t;

  state_t               state_reg, state_next;
  logic [index_w-1:0]   flush_set_reg, flush_set_next;
  logic [31:0]          vaddr_reg, paddr_reg, miss_addr_reg;
  logic [way_w-1:0]     rr_ptr_reg;
  logic                 miss_q_reg;
  logic                 update_pending_reg, inval_pending_reg;
  logic [index_w-1:0]   inval_index_reg;

  logic [index_w-1:0]   index_x, vaddr_index;
  logic [tag_w-1:0]     vaddr_tag, tag_m;
  logic [data_w-1:0]    new_data, hit_data;
  logic                 read_en, upd_go, hit, miss, fault;
  logic                 csr_ok, vaddr_wr, vaddr_latch, flush_cmd, inval_cmd, paddr_wr;

  logic                 hit_vec   [ways];
  logic                 set_valid [ways];
  logic [tag_w-1:0]     set_tag   [ways];
  logic [data_w-1:0]    data_x    [ways];

  logic                 found_match, found_inv, use_rr;
  logic [way_w-1:0]     match_way, inv_way, victim_way;

  assign index_x     = address_x[offset_w +: index_w];
  assign vaddr_index = vaddr_reg[offset_w +: index_w];
  assign vaddr_tag   = vaddr_reg[31 -: tag_w];
  assign tag_m       = address_m[31 -: tag_w];
  assign read_en     = !stall_x || !stall_m;
  // A reset in the same cycle as a pending update discards it.
  assign upd_go      = update_pending_reg && !rst_i;

`ifdef CFG_DTLB_WRITE_PROTECT_EN
  assign new_data = {paddr_reg[1], paddr_reg[31 -: pfn_w]};
`else
  assign new_data = paddr_reg[31 -: pfn_w];
`endif

  // CSR writes are honoured only in CHECK and only with bit0 set.
  assign csr_ok      = csr_write_enable && csr_write_data[0] && (state_reg == st_check);
  assign vaddr_wr    = csr_ok && (csr == csr_tlb_vaddress);
  assign vaddr_latch = vaddr_wr && (csr_write_data[5:1] == 5'h00);
  assign flush_cmd   = vaddr_wr && (csr_write_data[5:1] == 5'h01);
  assign inval_cmd   = vaddr_wr && (csr_write_data[5:1] == 5'h10);
  assign paddr_wr    = csr_ok && (csr == csr_tlb_paddress);

  for (genvar gi = 0; gi < ways; gi++) begin : g_way
    logic               valid_reg [sets];
    logic [tag_w-1:0]   tag_reg   [sets];
    logic [data_w-1:0]  data_mem  [sets];
    logic               valid_x_reg;
    logic [tag_w-1:0]   tag_x_reg;
    logic [data_w-1:0]  data_x_reg;
    logic               upd_we;

    assign upd_we = upd_go && (victim_way == way_w'(gi));

    always_ff @(posedge clk_i) begin
      if (state_reg == st_flush)
        valid_reg[flush_set_reg] <= 1'b0;
      else if (inval_pending_reg && !rst_i)
        valid_reg[inval_index_reg] <= 1'b0;
      else if (upd_we)
        valid_reg[vaddr_index] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (upd_we)
        tag_reg[vaddr_index] <= vaddr_tag;
      if (read_en) begin
        valid_x_reg <= valid_reg[index_x];
        tag_x_reg   <= tag_reg[index_x];
      end
    end

    always_ff @(posedge clk_i) begin
      if (upd_we)
        data_mem[vaddr_index] <= new_data;
      if (read_en)
        data_x_reg <= data_mem[index_x];
    end

    assign hit_vec[gi]   = valid_x_reg && (tag_x_reg == tag_m);
    assign data_x[gi]    = data_x_reg;
    assign set_valid[gi] = valid_reg[vaddr_index];
    assign set_tag[gi]   = tag_reg[vaddr_index];
  end

  // Lowest-index hit wins; scanning downward lets the lowest overwrite.
  always_comb begin
    hit      = 1'b0;
    hit_data = data_x[0];
    for (int w = ways - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_data = data_x[w];
      end
    end
  end

  always_comb begin
    found_match = 1'b0;
    found_inv   = 1'b0;
    match_way   = '0;
    inv_way     = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (set_valid[w] && (set_tag[w] == vaddr_tag)) begin
        found_match = 1'b1;
        match_way   = way_w'(w);
      end
      if (!set_valid[w]) begin
        found_inv = 1'b1;
        inv_way   = way_w'(w);
      end
    end
    use_rr     = !found_match && !found_inv;
    victim_way = found_match ? match_way : (found_inv ? inv_way : rr_ptr_reg);
  end

  assign miss = enable && (load_q_m || store_q_m) && !hit;

  always_comb begin
    state_next     = state_reg;
    flush_set_next = flush_set_reg;
    case (state_reg)
      st_check: begin
        if (flush_cmd) begin
          state_next     = st_flush;
          flush_set_next = '1;
        end
      end
      st_flush: begin
        flush_set_next = flush_set_reg - 1'b1;
        if (flush_set_reg == '0)
          state_next = st_check;
      end
      default: state_next = st_flush;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg          <= st_flush;
      flush_set_reg      <= '1;
      vaddr_reg          <= '0;
      paddr_reg          <= '0;
      rr_ptr_reg         <= '0;
      miss_q_reg         <= 1'b0;
      miss_addr_reg      <= '0;
      update_pending_reg <= 1'b0;
      inval_pending_reg  <= 1'b0;
      inval_index_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      flush_set_reg      <= flush_set_next;
      update_pending_reg <= paddr_wr;
      inval_pending_reg  <= inval_cmd;
      if (inval_cmd)
        inval_index_reg <= csr_write_data[offset_w +: index_w];
      if (vaddr_latch)
        vaddr_reg <= {csr_write_data[31:1], 1'b0};
      if (paddr_wr)
        paddr_reg <= csr_write_data;
      if (update_pending_reg && use_rr)
        rr_ptr_reg <= (rr_ptr_reg == way_w'(ways - 1)) ? '0 : rr_ptr_reg + 1'b1;
      if (exception_m)
        miss_q_reg <= 1'b0;
      else if (miss)
        miss_q_reg <= 1'b1;
      if ((state_reg == st_check) && (miss || fault))
        miss_addr_reg <= address_m;
    end
  end

`ifdef CFG_DTLB_WRITE_PROTECT_EN
  logic fault_q_reg, last_fault_reg;

  assign fault = enable && store_q_m && hit && !hit_data[data_w-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q_reg    <= 1'b0;
      last_fault_reg <= 1'b0;
    end else begin
      if (exception_m)
        fault_q_reg <= 1'b0;
      else if (fault)
        fault_q_reg <= 1'b1;
      if (state_reg == st_check) begin
        if (fault)
          last_fault_reg <= 1'b1;
        else if (miss)
          last_fault_reg <= 1'b0;
      end
    end
  end

  assign fault_int     = fault || fault_q_reg;
  assign csr_read_data = {miss_addr_reg[31:1], last_fault_reg};
`else
  assign fault         = 1'b0;
  assign fault_int     = 1'b0;
  assign csr_read_data = miss_addr_reg;
`endif

  assign physical_load_store_address_m = enable ? {hit_data[pfn_w-1:0], address_m[offset_w-1:0]}
                                                : address_m;
  assign miss_int      = miss || miss_q_reg;
  assign stall_request = (state_reg == st_flush);

  logic unused_bits;
  assign unused_bits = ^{address_x, vaddr_reg, paddr_reg, miss_addr_reg};
endmodule

// File: tb/tb_lm32_dtlb_nway.sv
// Scoreboard bench for lm32_dtlb_nway: stimulus queues expectations, a negedge monitor checks each qualified access.
module tb_lm32_dtlb_nway;
  logic        clk_i = 1'b0;
  logic        rst_i, enable, stall_x, stall_m, load_q_m, store_q_m, csr_write_enable, exception_m;
  logic [31:0] address_x, address_m, csr_write_data;
  logic [4:0]  csr;
  logic [31:0] physical_load_store_address_m, csr_read_data;
  logic        stall_request, miss_int, fault_int;

  localparam logic [4:0] CSR_PADDR = 5'h11;
  localparam logic [4:0] CSR_VADDR = 5'h12;

  always #5 clk_i = ~clk_i;

  lm32_dtlb_nway #(.ways(2), .sets(256), .page_size(4096)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .stall_x(stall_x), .stall_m(stall_m),
    .address_x(address_x), .address_m(address_m), .load_q_m(load_q_m), .store_q_m(store_q_m),
    .csr(csr), .csr_write_data(csr_write_data), .csr_write_enable(csr_write_enable),
    .exception_m(exception_m), .physical_load_store_address_m(physical_load_store_address_m),
    .stall_request(stall_request), .miss_int(miss_int), .fault_int(fault_int),
    .csr_read_data(csr_read_data)
  );

  typedef struct {
    string       name;
    logic [31:0] phys;
    logic        chk_phys;
    logic        miss;
    logic        fault;
    logic [31:0] csr_rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        missq_m = 1'b0;
  logic        faultq_m = 1'b0;
  logic [31:0] csr_m = 32'h0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every cycle with a qualified access in M is a DUT response.
  always @(negedge clk_i) begin
    if (load_q_m || store_q_m) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_access: got addr %h, required no access", address_m);
      end else begin
        mon_e = exp_q.pop_front();
        $display("access %-14s addr=%h phys=%h miss=%b fault=%b csr=%h stall=%b", mon_e.name,
                 address_m, physical_load_store_address_m, miss_int, fault_int, csr_read_data,
                 stall_request);
        check({mon_e.name, ".stall"}, 32'(stall_request), 32'h0);
        check({mon_e.name, ".miss"}, 32'(miss_int), 32'(mon_e.miss));
        check({mon_e.name, ".fault"}, 32'(fault_int), 32'(mon_e.fault));
        check({mon_e.name, ".csr"}, csr_read_data, mon_e.csr_rd);
        if (mon_e.chk_phys)
          check({mon_e.name, ".phys"}, physical_load_store_address_m, mon_e.phys);
      end
    end
  end

  task automatic csr_write(logic [4:0] a, logic [31:0] d);
    @(negedge clk_i);
    csr = a; csr_write_data = d; csr_write_enable = 1'b1;
    @(negedge clk_i);
    csr_write_enable = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic access(string name, logic [31:0] a, logic ld, logic st, logic en, logic exc,
                        logic exp_miss, logic exp_fault, logic chk_phys, logic [31:0] exp_phys);
    exp_t e;
    address_x = a; load_q_m = 1'b0; store_q_m = 1'b0;
    @(posedge clk_i); #1;
    address_m = a; load_q_m = ld; store_q_m = st; enable = en; exception_m = exc;
    e.name = name; e.phys = exp_phys; e.chk_phys = chk_phys;
    e.miss = exp_miss | missq_m; e.fault = exp_fault | faultq_m; e.csr_rd = csr_m;
    exp_q.push_back(e);
    missq_m  = exc ? 1'b0 : (exp_miss  ? 1'b1 : missq_m);
    faultq_m = exc ? 1'b0 : (exp_fault ? 1'b1 : faultq_m);
`ifdef CFG_DTLB_WRITE_PROTECT_EN
    if (exp_fault)     csr_m = {a[31:1], 1'b1};
    else if (exp_miss) csr_m = {a[31:1], 1'b0};
`else
    if (exp_miss) csr_m = a;
`endif
    @(posedge clk_i); #1;
    load_q_m = 1'b0; store_q_m = 1'b0; exception_m = 1'b0; enable = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_i = 1'b1; enable = 1'b0; stall_x = 1'b0; stall_m = 1'b0;
    load_q_m = 1'b0; store_q_m = 1'b0; exception_m = 1'b0;
    address_x = 32'h0; address_m = 32'h12345678;
    csr = 5'h0; csr_write_data = 32'h0; csr_write_enable = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.stall", 32'(stall_request), 32'h1);
    check("rst.miss", 32'(miss_int), 32'h0);
    check("rst.fault", 32'(fault_int), 32'h0);
    check("rst.csr", csr_read_data, 32'h0);
    check("rst.phys", physical_load_store_address_m, 32'h12345678);

    @(negedge clk_i);
    rst_i = 1'b0;
    cnt = 0;
    while (stall_request && cnt < 1000) begin
      cnt++;
      @(negedge clk_i);
    end
    $display("reset flush stall cycles=%0d", cnt);
    check("rst.flush_cycles", 32'(cnt), 32'd256);
    enable = 1'b1;

    access("miss_1000",   32'h00001000, 1, 0, 1, 0, 1, 0, 0, 32'h0);
    access("clear_1000",  32'h00001000, 1, 0, 0, 1, 0, 0, 1, 32'h00001000);

    csr_write(CSR_VADDR, 32'h00005001);
    csr_write(CSR_PADDR, 32'h8000A001);
    access("xlate_5123",  32'h00005123, 1, 0, 1, 0, 0, 0, 1, 32'h8000A123);

    csr_write(CSR_VADDR, 32'h00105001);
    csr_write(CSR_PADDR, 32'h9000B001);
    access("xlate_105abc", 32'h00105ABC, 1, 0, 1, 0, 0, 0, 1, 32'h9000BABC);

    // Third page on index 5: both ways valid, round-robin evicts way0.
    csr_write(CSR_VADDR, 32'h00205001);
    csr_write(CSR_PADDR, 32'hA000C003);
    access("xlate_205010", 32'h00205010, 1, 0, 1, 0, 0, 0, 1, 32'hA000C010);
    access("store_205020", 32'h00205020, 0, 1, 1, 0, 0, 0, 1, 32'hA000C020);
    access("evicted_5000", 32'h00005000, 1, 0, 1, 0, 1, 0, 0, 32'h0);
    access("kept_105000",  32'h00105000, 1, 0, 1, 1, 0, 0, 1, 32'h9000B000);
    access("kept_105004",  32'h00105004, 1, 0, 1, 0, 0, 0, 1, 32'h9000B004);

    csr_write(CSR_VADDR, 32'h00005021);
    access("inval_105000", 32'h00105000, 1, 0, 1, 0, 1, 0, 0, 32'h0);
    access("inval_exc",    32'h00205000, 1, 0, 1, 1, 1, 0, 0, 32'h0);
    access("missq_clear",  32'h00205000, 1, 0, 0, 0, 0, 0, 1, 32'h00205000);

`ifdef CFG_DTLB_WRITE_PROTECT_EN
    csr_write(CSR_VADDR, 32'h00007001);
    csr_write(CSR_PADDR, 32'h8000D001);
    access("wp_store",     32'h00007044, 0, 1, 1, 0, 0, 1, 1, 32'h8000D044);
    access("wp_clear",     32'h00007048, 1, 0, 1, 1, 0, 0, 1, 32'h8000D048);
    access("wp_load",      32'h0000704C, 1, 0, 1, 0, 0, 0, 1, 32'h8000D04C);
`endif

    csr_write(CSR_VADDR, 32'h00000003);
    check("flush_cmd.stall", 32'(stall_request), 32'h1);
    cnt = 0;
    while (stall_request && cnt < 1000) begin
      cnt++;
      @(negedge clk_i);
    end
    check("flush_cmd.done", 32'(stall_request), 32'h0);
    access("flushed_205010", 32'h00205010, 1, 0, 1, 0, 1, 0, 0, 32'h0);

    repeat (2) @(posedge clk_i);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
